// File: rtl/rom_port_arbiter_if.sv
// rtl/rom_port_arbiter_if.sv - requester-side bundle of the dual-port ROM arbiter
// Signals:
//   hold       stall new grants
//   req_valid  per-requester read request
//   req_addr   flattened request addresses, requester i at [i*AWIDTH +: AWIDTH]
//   req_ready  per-requester grant
//   resp_valid per-requester one-cycle response pulse
//   resp_data  flattened response words, requester i at [i*DWIDTH +: DWIDTH]
//   busy       a read is in flight
// master = lane side, slave = arbiter side.
interface rom_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8
);
    logic                        hold;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*AWIDTH-1:0]   req_addr;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          resp_valid;
    logic [NUM_REQ*DWIDTH-1:0]   resp_data;
    logic                        busy;

    modport master (
        output hold, req_valid, req_addr,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  hold, req_valid, req_addr,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin sharing of a dual-port ROM among NUM_REQ requesters
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_if (slave)     requester handshake, responses and busy
//   rom_address_a/b    addresses to ROM ports A and B
//   rom_q_a/b          ROM read data, valid ROM_LATENCY cycles after the address
module rom_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int AWIDTH      = 8,
    parameter int DWIDTH      = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_port_arbiter_if.slave req_if,
    output logic [AWIDTH-1:0] rom_address_a,
    output logic [AWIDTH-1:0] rom_address_b,
    input  logic [DWIDTH-1:0] rom_q_a,
    input  logic [DWIDTH-1:0] rom_q_b
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TD = (ROM_LATENCY > 0) ? ROM_LATENCY : 1;

    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         ga;
    logic [IW-1:0]         gb;
    logic                  found_a;
    logic                  found_b;
    logic                  grant_a;
    logic                  grant_b;
    logic [NUM_REQ-1:0]    ready;
    logic                  exit_v_a;
    logic                  exit_v_b;
    logic [IW-1:0]         exit_i_a;
    logic [IW-1:0]         exit_i_b;
    logic                  tags_busy;
    logic [NUM_REQ-1:0]    resp_valid_q;
    logic [NUM_REQ*DWIDTH-1:0] resp_data_q;
    logic                  busy_q;

    // (base + k) mod NUM_REQ for base < NUM_REQ and k < NUM_REQ
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // Port A takes the first valid requester at or after rr_ptr; port B the
    // next one after ga, which can never be ga itself.
    always_comb begin
        found_a = 1'b0;
        ga      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_a && req_if.req_valid[wrap_add(rr_ptr, k)]) begin
                found_a = 1'b1;
                ga      = wrap_add(rr_ptr, k);
            end
        end
        found_b = 1'b0;
        gb      = '0;
        for (int k = 1; k < NUM_REQ; k++) begin
            if (!found_b && req_if.req_valid[wrap_add(ga, k)]) begin
                found_b = 1'b1;
                gb      = wrap_add(ga, k);
            end
        end
    end

    assign grant_a = found_a & ~req_if.hold;
    assign grant_b = found_b & ~req_if.hold;

    always_comb begin
        ready = '0;
        if (grant_a) ready[ga] = 1'b1;
        if (grant_b) ready[gb] = 1'b1;
    end

    assign req_if.req_ready = ready;
    assign rom_address_a    = grant_a ? req_if.req_addr[int'(ga)*AWIDTH +: AWIDTH] : '0;
    assign rom_address_b    = grant_b ? req_if.req_addr[int'(gb)*AWIDTH +: AWIDTH] : '0;

    // Tag pipelines follow each port's read through the ROM so the returned
    // word can be steered back to whoever issued it.
    generate
        if (ROM_LATENCY == 0) begin : g_comb_rom
            assign exit_v_a  = grant_a;
            assign exit_i_a  = ga;
            assign exit_v_b  = grant_b;
            assign exit_i_b  = gb;
            assign tags_busy = 1'b0;
        end else begin : g_tag_pipe
            logic [TD-1:0] tag_v_a;
            logic [TD-1:0] tag_v_b;
            logic [IW-1:0] tag_i_a [TD];
            logic [IW-1:0] tag_i_b [TD];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_v_a <= '0;
                    tag_v_b <= '0;
                    for (int s = 0; s < TD; s++) begin
                        tag_i_a[s] <= '0;
                        tag_i_b[s] <= '0;
                    end
                end else begin
                    tag_v_a[0] <= grant_a;
                    tag_i_a[0] <= ga;
                    tag_v_b[0] <= grant_b;
                    tag_i_b[0] <= gb;
                    for (int s = 1; s < TD; s++) begin
                        tag_v_a[s] <= tag_v_a[s-1];
                        tag_i_a[s] <= tag_i_a[s-1];
                        tag_v_b[s] <= tag_v_b[s-1];
                        tag_i_b[s] <= tag_i_b[s-1];
                    end
                end
            end

            assign exit_v_a  = tag_v_a[TD-1];
            assign exit_i_a  = tag_i_a[TD-1];
            assign exit_v_b  = tag_v_b[TD-1];
            assign exit_i_b  = tag_i_b[TD-1];
            assign tags_busy = (|tag_v_a) | (|tag_v_b);
        end
    endgenerate

    // A requester holds at most one grant per cycle, so the two exiting tags
    // never name the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            if (exit_v_a) begin
                resp_valid_q[exit_i_a]                         <= 1'b1;
                resp_data_q[int'(exit_i_a)*DWIDTH +: DWIDTH]   <= rom_q_a;
            end
            if (exit_v_b) begin
                resp_valid_q[exit_i_b]                         <= 1'b1;
                resp_data_q[int'(exit_i_b)*DWIDTH +: DWIDTH]   <= rom_q_b;
            end
            // Next-cycle tags are this cycle's grants plus all but the last
            // stage; the last stage becomes next cycle's resp_valid.
            busy_q <= grant_a | grant_b | tags_busy;
            if (grant_b) begin
                rr_ptr <= wrap_add(gb, 1);
            end else if (grant_a) begin
                rr_ptr <= wrap_add(ga, 1);
            end
        end
    end

    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;
    assign req_if.busy       = busy_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter
module tb_rom_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int L  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rom_address_a;
    logic [AW-1:0] rom_address_b;
    logic [DW-1:0] rom_q_a;
    logic [DW-1:0] rom_q_b;
    logic [DW-1:0] mem [256];

    rom_port_arbiter_if #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) bus ();

    rom_port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .ROM_LATENCY(L)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_if        (bus),
        .rom_address_a (rom_address_a),
        .rom_address_b (rom_address_b),
        .rom_q_a       (rom_q_a),
        .rom_q_b       (rom_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_q_a <= mem[rom_address_a];
        rom_q_b <= mem[rom_address_b];
    end

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } pend_t;

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              m_rr = 0;
    bit              model_on = 1'b0;
    pend_t           pend[$];
    logic [N*DW-1:0] m_data = '0;
    int              waitc[N];
    logic [N-1:0]    last_grant = '0;
    logic [N-1:0]    v_vec = '0;
    logic [AW-1:0]   a_arr[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.req_valid = v_vec;
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = a_arr[i];
    endtask

    // Reference: the first two valid requesters in cyclic order from the
    // pointer are granted; each grant returns mem[addr] L+1 cycles later.
    task automatic model_step();
        int            ga;
        int            gb;
        int            idx;
        logic [N-1:0]  er;
        logic [N-1:0]  ev;
        logic [AW-1:0] ea;
        logic [AW-1:0] eb;
        bit            b;
        ga = -1;
        gb = -1;
        if (!bus.hold) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (bus.req_valid[idx]) begin
                    if (ga < 0) ga = idx;
                    else if (gb < 0) gb = idx;
                end
            end
        end
        er = '0;
        ea = '0;
        eb = '0;
        if (ga >= 0) begin er[ga] = 1'b1; ea = a_arr[ga]; end
        if (gb >= 0) begin er[gb] = 1'b1; eb = a_arr[gb]; end
        chk("req_ready", bus.req_ready, er);
        chk("rom_address_a", rom_address_a, ea);
        chk("rom_address_b", rom_address_b, eb);

        ev = '0;
        for (int j = pend.size() - 1; j >= 0; j--) begin
            if (pend[j].due == cyc) begin
                ev[pend[j].idx] = 1'b1;
                m_data[pend[j].idx*DW +: DW] = pend[j].data;
                pend.delete(j);
            end
        end
        chk("resp_valid", bus.resp_valid, ev);
        chk("resp_data", bus.resp_data, m_data);
        b = (ev != '0);
        foreach (pend[j]) if (pend[j].due <= cyc + L) b = 1'b1;
        chk("busy", bus.busy, b);

        for (int i = 0; i < N; i++) begin
            if (!bus.req_valid[i]) begin
                waitc[i] = 0;
            end else if (!bus.hold) begin
                if (bus.req_ready[i]) begin
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                    chk("fair_wait_exceeded", waitc[i] > 1, 0);
                end
            end
            if (er[i]) pend.push_back('{due: cyc + L + 1, idx: i, data: mem[a_arr[i]]});
        end
        last_grant = er;
        if (gb >= 0) m_rr = (gb + 1) % N;
        else if (ga >= 0) m_rr = (ga + 1) % N;
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (model_on) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        rst_n    = 1'b0;
        model_on = 1'b0;
        pend.delete();
        m_rr       = 0;
        m_data     = '0;
        last_grant = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        model_on = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[8'h3C] = 8'hA5;
        mem[8'h10] = 8'h5A;
        for (int i = 0; i < N; i++) a_arr[i] = 8'(i * 16 + 3);
        bus.hold = 1'b0;

        // reset state, then round-robin with everyone valid, then hold
        v_vec = '1;
        drive();
        assert_reset();
        #1;
        chk("reset_resp_valid", bus.resp_valid, 0);
        chk("reset_resp_data", bus.resp_data, 0);
        chk("reset_busy", bus.busy, 0);
        release_reset();
        #1;
        chk("rr_c0", bus.req_ready, 4'b0011);
        cycle();
        chk("rr_c1", bus.req_ready, 4'b1100);
        cycle();
        chk("rr_c2", bus.req_ready, 4'b0011);
        cycle();
        bus.hold = 1'b1;
        #1;
        chk("hold_c3_ready", bus.req_ready, 4'b0000);
        cycle();
        chk("hold_c4_ready", bus.req_ready, 4'b0000);
        chk("hold_c4_resp", bus.resp_valid, 4'b0011);
        cycle();
        chk("hold_c5_ready", bus.req_ready, 4'b0000);
        cycle();
        bus.hold = 1'b0;
        #1;
        chk("after_hold_ready", bus.req_ready, 4'b1100);
        cycle();
        v_vec = '0;
        drive();
        repeat (4) cycle();

        // single read from requester 2
        v_vec    = 4'b0100;
        a_arr[2] = 8'h3C;
        drive();
        #1;
        chk("single_ready", bus.req_ready, 4'b0100);
        chk("single_addr_a", rom_address_a, 8'h3C);
        chk("single_addr_b", rom_address_b, 8'h00);
        cycle();
        v_vec = '0;
        drive();
        #1;
        chk("single_resp_early", bus.resp_valid, 4'b0000);
        cycle();
        chk("single_resp_valid", bus.resp_valid, 4'b0100);
        chk("single_resp_data", bus.resp_data[23:16], 8'hA5);
        repeat (2) cycle();

        // same address on both ports
        v_vec    = 4'b1010;
        a_arr[1] = 8'h10;
        a_arr[3] = 8'h10;
        drive();
        #1;
        chk("same_ready", bus.req_ready, 4'b1010);
        chk("same_addr_a", rom_address_a, 8'h10);
        chk("same_addr_b", rom_address_b, 8'h10);
        cycle();
        v_vec = '0;
        drive();
        cycle();
        chk("same_resp_valid", bus.resp_valid, 4'b1010);
        chk("same_resp_data1", bus.resp_data[15:8], 8'h5A);
        chk("same_resp_data3", bus.resp_data[31:24], 8'h5A);
        repeat (2) cycle();

        // reset while two reads are in flight
        v_vec = 4'b0101;
        drive();
        cycle();
        v_vec = '0;
        drive();
        #2;
        chk("midrst_busy_before", bus.busy, 1);
        assert_reset();
        #1;
        chk("midrst_resp_valid", bus.resp_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        release_reset();
        repeat (5) cycle();

        // random stress; a waiting requester keeps its request stable
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v_vec[i] && !last_grant[i])) begin
                    v_vec[i] = ($urandom_range(0, 99) < 60);
                    a_arr[i] = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
                end
            end
            bus.hold = ($urandom_range(0, 99) < 5);
            drive();
            cycle();
        end
        v_vec    = '0;
        bus.hold = 1'b0;
        drive();
        repeat (4) cycle();
        chk("drain_pending", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
